// File: rtl/srl_shift_core.sv
// Enable-gated shift chain with a dynamic read tap.
// No reset on storage so synthesis can map it onto SRL16/SRL32 primitives.
module srl_shift_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic [WIDTH-1:0]         d,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[addr];

endmodule

// File: rtl/srl_fifo.sv
// Shallow FIFO on an SRL shift chain: newest word enters at stage 0,
// the oldest word is read from the tap at index count-1.
module srl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW  = $clog2(DEPTH + 1);
    localparam int ADW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [AW-1:0]  count_next;
    logic [ADW-1:0] rd_addr, rd_addr_next;
    logic           push, pop;

    // Flags come from registered state only, never from the handshake inputs.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    srl_shift_core #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_core (
        .clk  (clk),
        .ce   (push),
        .d    (in_data),
        .addr (rd_addr),
        .q    (out_data)
    );

    always_comb begin
        state_next   = state;
        count_next   = count;
        rd_addr_next = rd_addr;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = PARTIAL;
                    count_next = AW'(1);
                end
            end
            PARTIAL: begin
                if (push && !pop) begin
                    count_next   = count + AW'(1);
                    rd_addr_next = rd_addr + ADW'(1);
                    if (count == AW'(DEPTH - 1)) state_next = FULL;
                end else if (pop && !push) begin
                    count_next = count - AW'(1);
                    if (count == AW'(1)) begin
                        state_next   = EMPTY;
                        rd_addr_next = '0;
                    end else begin
                        rd_addr_next = rd_addr - ADW'(1);
                    end
                end
            end
            FULL: begin
                if (pop) begin
                    state_next   = PARTIAL;
                    count_next   = count - AW'(1);
                    rd_addr_next = rd_addr - ADW'(1);
                end
            end
            default: begin
                state_next   = EMPTY;
                count_next   = '0;
                rd_addr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            count   <= '0;
            rd_addr <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            rd_addr <= rd_addr_next;
        end
    end

endmodule

// File: tb/tb_srl_fifo.sv
// Directed bench for srl_fifo (WIDTH=8, DEPTH=16).
module tb_srl_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;

    int errors = 0;
    int checks = 0;

    srl_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_iready", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_count", 32'(count), 0);
            chk("idle_ovalid", 32'(out_valid), 0);
            chk("idle_iready", 32'(in_ready), 1);
        end

        // three pushes, head visible one cycle after the first push
        push_word(8'h11);
        chk("p1_ovalid", 32'(out_valid), 1);
        chk("p1_data", 32'(out_data), 32'h11);
        push_word(8'h22);
        chk("p2_data", 32'(out_data), 32'h11);
        push_word(8'h33);
        chk("p3_count", 32'(count), 3);
        chk("p3_data", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        chk("d1", 32'(out_data), 32'h11); step();
        chk("d2", 32'(out_data), 32'h22); step();
        chk("d3", 32'(out_data), 32'h33); step();
        out_ready = 1'b0;
        chk("d_count", 32'(count), 0);
        chk("d_ovalid", 32'(out_valid), 0);

        // fill to full, then offer 0xAA which must be refused
        for (int i = 0; i < 16; i++) push_word(8'(i));
        chk("full_count", 32'(count), 16);
        chk("full_iready", 32'(in_ready), 0);
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_hold_count", 32'(count), 16);
            chk("full_hold_iready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        chk("full_pop_data", 32'(out_data), 0);
        step();
        in_valid = 1'b0;
        chk("full_pop_count", 32'(count), 15);
        for (int i = 1; i < 16; i++) begin
            chk("drain_valid", 32'(out_valid), 1);
            chk("drain_data", 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_ovalid", 32'(out_valid), 0);

        // steady state at count=5 with simultaneous push and pop
        for (int i = 0; i < 5; i++) push_word(8'h30 + 8'(i));
        chk("ss_start", 32'(count), 5);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h40 + 8'(i);
            chk("ss_data", 32'(out_data),
                (i < 5) ? 32'h30 + 32'(i) : 32'h40 + 32'(i - 5));
            step();
            chk("ss_count", 32'(count), 5);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("ss_tail", 32'(out_data), 32'h45 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("ss_end", 32'(count), 0);

        // 1 -> empty, then single push
        push_word(8'h99);
        out_ready = 1'b1;
        chk("one_data", 32'(out_data), 32'h99);
        step();
        out_ready = 1'b0;
        chk("one_count", 32'(count), 0);
        chk("one_ovalid", 32'(out_valid), 0);
        push_word(8'h5A);
        chk("5a_valid", 32'(out_valid), 1);
        chk("5a_data", 32'(out_data), 32'h5A);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("5a_empty", 32'(count), 0);

        // reset in the middle of a push at count=9
        for (int i = 0; i < 9; i++) push_word(8'h80 + 8'(i));
        chk("mid_count", 32'(count), 9);
        in_valid = 1'b1; in_data = 8'h89; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_count", 32'(count), 0);
        chk("mrst_ovalid", 32'(out_valid), 0);
        chk("mrst_iready", 32'(in_ready), 1);
        push_word(8'h77);
        chk("post_count", 32'(count), 1);
        chk("post_data", 32'(out_data), 32'h77);
        chk("post_valid", 32'(out_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
